// File: rtl/cnn_stream_feeder.sv
// Byte-serial feeder for the CNN accelerator input port: streams per-pass weights,
// then the three input rows for each output row, behind a valid/ready handshake.
module cnn_stream_feeder #(
    parameter int unsigned IMG_W         = 26,
    parameter int unsigned FILT_PER_PASS = 2,
    parameter int unsigned NUM_PASS      = 16,
    parameter int unsigned WA_W          = 9,
    parameter int unsigned PA_W          = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [7:0]      o_data,
    output logic            o_is_wgt,
    output logic            o_sop,
    output logic            o_eop,
    output logic [3:0]      pass_idx,
    output logic            busy,
    output logic            done,
    output logic            wgt_rd_en,
    output logic [WA_W-1:0] wgt_addr,
    input  logic [7:0]      wgt_rdata,
    output logic            pix_rd_en,
    output logic [PA_W-1:0] pix_addr,
    input  logic [7:0]      pix_rdata
);

    localparam int unsigned W_N  = 9 * FILT_PER_PASS;
    localparam int unsigned K_N  = 3 * IMG_W;
    localparam int unsigned J_N  = IMG_W - 2;
    localparam int unsigned W_CW = $clog2(W_N);
    localparam int unsigned K_CW = $clog2(K_N);
    localparam int unsigned J_CW = $clog2(J_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WGT   = 2'd1,
        PIX   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      p;
    logic [W_CW-1:0] w;
    logic [J_CW-1:0] j;
    logic [K_CW-1:0] k;

    logic adv;
    logic issue_w;
    logic issue_p;
    logic w_last;
    logic k_last;
    logic j_last;
    logic p_last;

    // The output register may be refilled when empty or being drained this cycle.
    assign adv     = ~o_valid | i_ready;
    assign issue_w = adv & (state == WGT);
    assign issue_p = adv & (state == PIX);

    assign w_last = (w == W_CW'(W_N - 1));
    assign k_last = (k == K_CW'(K_N - 1));
    assign j_last = (j == J_CW'(J_N - 1));
    assign p_last = (p == 4'(NUM_PASS - 1));

    // Reads only fire on issue, so a stall leaves memory data parked on the output.
    assign wgt_rd_en = issue_w;
    assign pix_rd_en = issue_p;
    assign wgt_addr  = WA_W'(p) * WA_W'(W_N) + WA_W'(w);
    assign pix_addr  = PA_W'(j) * PA_W'(IMG_W) + PA_W'(k);
    assign o_data    = o_is_wgt ? wgt_rdata : pix_rdata;

    // Sequencer: walks pass/weight/row/column counters and registers the stream flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            p        <= '0;
            w        <= '0;
            j        <= '0;
            k        <= '0;
            o_valid  <= 1'b0;
            o_is_wgt <= 1'b0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            pass_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (adv) begin
                        o_valid <= 1'b0;
                    end
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state <= WGT;
                        busy  <= 1'b1;
                        p     <= '0;
                        w     <= '0;
                        j     <= '0;
                        k     <= '0;
                    end
                end
                WGT: begin
                    if (adv) begin
                        o_valid  <= 1'b1;
                        o_is_wgt <= 1'b1;
                        o_sop    <= (w == '0);
                        o_eop    <= 1'b0;
                        pass_idx <= p;
                        if (w_last) begin
                            w     <= '0;
                            state <= PIX;
                        end else begin
                            w <= w + W_CW'(1);
                        end
                    end
                end
                PIX: begin
                    if (adv) begin
                        o_valid  <= 1'b1;
                        o_is_wgt <= 1'b0;
                        o_sop    <= 1'b0;
                        o_eop    <= j_last & k_last;
                        pass_idx <= p;
                        if (k_last) begin
                            k <= '0;
                            if (j_last) begin
                                j <= '0;
                                if (p_last) begin
                                    state <= FLUSH;
                                end else begin
                                    p     <= p + 4'd1;
                                    state <= WGT;
                                end
                            end else begin
                                j <= j + J_CW'(1);
                            end
                        end else begin
                            k <= k + K_CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (adv) begin
                        o_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_feeder.sv
// Self-checking bench for cnn_stream_feeder: random memories, random backpressure,
// expected stream built from filter/row/column loops.
module tb_cnn_stream_feeder;

    localparam int IMG_W    = 26;
    localparam int FPP      = 2;
    localparam int NUM_PASS = 16;
    localparam int WPP      = 9 * FPP;
    localparam int PER_PASS = WPP + (IMG_W - 2) * 3 * IMG_W;
    localparam int LAYER    = PER_PASS * NUM_PASS;
    localparam int ROM_N    = WPP * NUM_PASS;
    localparam int RAM_N    = IMG_W * IMG_W;

    logic       clk;
    logic       rst;
    logic       start;
    logic       i_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_is_wgt;
    logic       o_sop;
    logic       o_eop;
    logic [3:0] pass_idx;
    logic       busy;
    logic       done;
    logic       wgt_rd_en;
    logic [8:0] wgt_addr;
    logic [7:0] wgt_rdata;
    logic       pix_rd_en;
    logic [9:0] pix_addr;
    logic [7:0] pix_rdata;

    cnn_stream_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_is_wgt  (o_is_wgt),
        .o_sop     (o_sop),
        .o_eop     (o_eop),
        .pass_idx  (pass_idx),
        .busy      (busy),
        .done      (done),
        .wgt_rd_en (wgt_rd_en),
        .wgt_addr  (wgt_addr),
        .wgt_rdata (wgt_rdata),
        .pix_rd_en (pix_rd_en),
        .pix_addr  (pix_addr),
        .pix_rdata (pix_rdata)
    );

    logic [7:0] rom  [0:ROM_N-1];
    logic [7:0] sram [0:RAM_N-1];

    logic [7:0] e_data [0:LAYER-1];
    logic [6:0] e_flag [0:LAYER-1];
    logic [7:0] g_data [0:LAYER-1];
    logic [6:0] g_flag [0:LAYER-1];

    int   checks   = 0;
    int   errors   = 0;
    int   idx      = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;
    int   hold     = 0;
    bit   mon_en   = 0;
    bit   prev_stall = 0;
    logic [7:0] sv_data;
    logic [7:0] sv_flag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memories: data follows an enabled read and holds otherwise.
    always @(posedge clk) begin
        if (wgt_rd_en) wgt_rdata <= rom[wgt_addr];
        if (pix_rd_en) pix_rdata <= sram[pix_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: 0 = low, 1 = high, 2 = random with a 20-cycle hold at byte 17.
    initial begin
        i_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) i_ready = 1'b0;
            else if (rdy_mode == 1) i_ready = 1'b1;
            else if (idx == 17 && hold < 20) begin
                i_ready = 1'b0;
                hold++;
            end else i_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard accepted bytes and verify stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) prev_stall = 0;
            else begin
                if (prev_stall) begin
                    check("stall_data", 32'(o_data), 32'(sv_data));
                    check("stall_flags", 32'({o_valid, o_is_wgt, o_sop, o_eop, pass_idx}), 32'(sv_flag));
                end
                if (o_valid && !i_ready)
                    check("stall_rd_en", 32'({wgt_rd_en, pix_rd_en}), 32'(0));
                if (done) begin
                    done_cnt++;
                    check("busy_at_done", 32'(busy), 32'(0));
                end
                if (o_valid && i_ready) begin
                    if (idx < LAYER) begin
                        check("data", 32'(o_data), 32'(e_data[idx]));
                        check("flags", 32'({o_is_wgt, o_sop, o_eop, pass_idx}), 32'(e_flag[idx]));
                        g_data[idx] = o_data;
                        g_flag[idx] = {o_is_wgt, o_sop, o_eop, pass_idx};
                    end else check("overrun", 32'(idx), 32'(LAYER - 1));
                    idx++;
                end
                prev_stall = o_valid && !i_ready;
                sv_data    = o_data;
                sv_flag    = {o_valid, o_is_wgt, o_sop, o_eop, pass_idx};
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idx(input int target, input int budget, input string tag);
        int n = 0;
        while (idx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(idx >= target), 32'(1));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check(tag, 32'(done), 32'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, 32'({o_valid, o_is_wgt, o_sop, o_eop, busy, done, wgt_rd_en, pix_rd_en}), 32'(0));
        check({tag, "_pass"}, 32'(pass_idx), 32'(0));
        check({tag, "_addr"}, 32'({wgt_addr, pix_addr}), 32'(0));
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < RAM_N; i++) sram[i] = 8'($urandom);

        // Reference stream: per pass, all weights, then rows j..j+2 for every output row.
        n = 0;
        for (int p = 0; p < NUM_PASS; p++) begin
            for (int w = 0; w < WPP; w++) begin
                e_data[n] = rom[p * WPP + w];
                e_flag[n] = {1'b1, 1'(w == 0), 1'b0, 4'(p)};
                n++;
            end
            for (int j = 0; j < IMG_W - 2; j++)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < IMG_W; c++) begin
                        e_data[n] = sram[(j + r) * IMG_W + c];
                        e_flag[n] = {1'b0, 1'b0, 1'(j == IMG_W - 3 && r == 2 && c == IMG_W - 1), 4'(p)};
                        n++;
                    end
        end

        #1 check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en   = 1;
        rdy_mode = 1;

        // Nominal layer with ready held high, including start latency.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_rise", 32'({busy, o_valid}), 32'(2'b10));
        @(negedge clk);
        check("first_valid", 32'({o_valid, o_is_wgt, o_sop}), 32'(3'b111));
        wait_done(LAYER + 100, "done_nominal");
        check("count_nominal", 32'(idx), 32'(LAYER));
        check("done_cnt_nominal", 32'(done_cnt), 32'(1));
        check("byte17_rom", 32'(g_data[17]), 32'(rom[17]));
        check("byte18_sram", 32'(g_data[18]), 32'(sram[0]));
        check("byte96_sram", 32'(g_data[96]), 32'(sram[26]));
        check("eop_byte", 32'(g_data[PER_PASS - 1]), 32'(sram[675]));
        check("eop_flag", 32'(g_flag[PER_PASS - 1]), 32'(7'b0010000));
        check("pass1_flags", 32'(g_flag[PER_PASS]), 32'(7'b1100001));
        check("pass1_data", 32'(g_data[PER_PASS]), 32'(rom[18]));

        // Back-to-back layer under backpressure with a redundant start at byte 1000.
        idx      = 0;
        done_cnt = 0;
        hold     = 0;
        rdy_mode = 2;
        pulse_start();
        wait_idx(1000, 4000, "reach_1000");
        pulse_start();
        wait_idx(6000, 20000, "reach_6000");
        check("hold_applied", 32'(hold), 32'(20));
        rdy_mode = 1;
        wait_done(LAYER + 100, "done_bp");
        check("count_bp", 32'(idx), 32'(LAYER));
        check("first_sop_bp", 32'(g_data[0]), 32'(rom[0]));
        repeat (3) @(negedge clk);
        check("done_cnt_bp", 32'(done_cnt), 32'(1));
        check("idle_after_bp", 32'({o_valid, busy}), 32'(0));

        // Reset mid-stream, then restart from the beginning.
        idx      = 0;
        done_cnt = 0;
        pulse_start();
        wait_idx(5000, 6000, "reach_5000");
        @(posedge clk);
        #2 rst = 1'b1;
        mon_en = 0;
        #1 check_idle_outputs("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idx    = 0;
        mon_en = 1;
        pulse_start();
        wait_idx(100, 400, "restart");
        check("restart_data", 32'(g_data[0]), 32'(rom[0]));
        check("restart_flags", 32'(g_flag[0]), 32'(7'b1100000));
        check("done_cnt_reset", 32'(done_cnt), 32'(0));

        mon_en = 0;
        rst    = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
